// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
// State encoding and bus widths used across the arbiter slice.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int I2C_ADDR_W  = 7;
  localparam int I2C_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 1000;
  localparam int DEF_CNT_W   = 10;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// GNT is the index of the winner; UPD commits it as last served.
module rr_arb2 (
  input  logic CLK,
  input  logic RESET,
  input  logic VALID0,
  input  logic VALID1,
  input  logic UPD,
  output logic GNT
);

  logic last;

  // A tie goes to the port not served last.
  always_comb begin
    GNT = VALID1;
    if (VALID0 && VALID1)
      GNT = ~last;
  end

  always_ff @(posedge CLK) begin
    if (!RESET)
      last <= 1'b1;
    else if (UPD)
      last <= GNT;
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between a host port and a poll port,
// with round-robin grant and a WAIT-state watchdog.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ0_VALID,
  input  logic                  REQ0_RNW,
  input  logic [I2C_ADDR_W-1:0] REQ0_ADDR,
  input  logic [I2C_DATA_W-1:0] REQ0_WDATA,
  output logic                  REQ0_READY,
  output logic                  REQ0_DONE,
  input  logic                  REQ1_VALID,
  input  logic                  REQ1_RNW,
  input  logic [I2C_ADDR_W-1:0] REQ1_ADDR,
  input  logic [I2C_DATA_W-1:0] REQ1_WDATA,
  output logic                  REQ1_READY,
  output logic                  REQ1_DONE,
  output logic [I2C_DATA_W-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  START_STB,
  output logic                  RNW,
  output logic [I2C_ADDR_W-1:0] I2C_ADDR,
  output logic [I2C_DATA_W-1:0] WR_DATA,
  input  logic                  I2C_DONE,
  input  logic [I2C_DATA_W-1:0] I2C_RD_DATA,
  output logic                  BUSY
);

  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             gnt;
  logic             gnt_q;
  logic             arb_upd;
  logic             finish;
  logic             wd_hit;
  logic [CNT_W-1:0] wd;

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RESET  (RESET),
    .VALID0 (REQ0_VALID),
    .VALID1 (REQ1_VALID),
    .UPD    (arb_upd),
    .GNT    (gnt)
  );

  assign wd_hit = (wd == WD_LAST);
  assign finish = (state == WAIT) &&
                  (state_nxt == RESP);

  always_comb begin
    state_nxt = state;
    arb_upd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (REQ0_VALID || REQ1_VALID) begin
          state_nxt = LAUNCH;
          arb_upd   = 1'b1;
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (I2C_DONE || wd_hit)
          state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      gnt_q      <= 1'b0;
      wd         <= '0;
      BUSY       <= 1'b0;
      START_STB  <= 1'b0;
      REQ0_READY <= 1'b0;
      REQ1_READY <= 1'b0;
      REQ0_DONE  <= 1'b0;
      REQ1_DONE  <= 1'b0;
      RNW        <= 1'b0;
      I2C_ADDR   <= '0;
      WR_DATA    <= '0;
      RSP_RDATA  <= '0;
      RSP_ERR    <= 1'b0;
    end else begin
      BUSY       <= (state_nxt != IDLE);
      START_STB  <= arb_upd;
      REQ0_READY <= arb_upd && !gnt;
      REQ1_READY <= arb_upd && gnt;
      REQ0_DONE  <= finish && !gnt_q;
      REQ1_DONE  <= finish && gnt_q;
      if (arb_upd) begin
        gnt_q    <= gnt;
        RNW      <= gnt ? REQ1_RNW   : REQ0_RNW;
        I2C_ADDR <= gnt ? REQ1_ADDR  : REQ0_ADDR;
        WR_DATA  <= gnt ? REQ1_WDATA : REQ0_WDATA;
      end
      // Counter stops at WD_LAST; RESP is taken first.
      if (state == LAUNCH)
        wd <= '0;
      else if (state == WAIT && !wd_hit)
        wd <= wd + 1'b1;
      // A completion on the last watchdog cycle beats the timeout.
      if (finish) begin
        RSP_ERR   <= !I2C_DONE;
        RSP_RDATA <= (I2C_DONE && RNW) ?
                     I2C_RD_DATA : '0;
      end
    end
  end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares the single I2C master controller between two requesters: a host/CPU port (port 0) and a housekeeping/poll port (port 1).
- Arbitrates round-robin and latches the winning request.
- Drives the controller's START_STB/RNW/I2C_ADDR/WR_DATA, then waits for completion or a watchdog timeout.
- Returns read data and status to the granted requester. Sits between the requesters and the I2C master.

Parameters:
- TIMEOUT, 1000, WAIT-state cycles allowed before the transaction is declared hung (must be ≥ 2).
- CNT_W, 10, width of the watchdog counter (2^CNT_W > TIMEOUT).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-low reset
- REQ0_VALID  in  1  port 0 request; held until REQ0_READY
- REQ0_RNW  in  1  port 0 direction: 1 = read, 0 = write
- REQ0_ADDR  in  7  port 0 7-bit target address
- REQ0_WDATA  in  16  port 0 write data
- REQ0_READY  out  1  one-cycle pulse: port 0 request accepted
- REQ0_DONE  out  1  one-cycle pulse: port 0 transaction finished
- REQ1_VALID, REQ1_RNW, REQ1_ADDR, REQ1_WDATA, REQ1_READY, REQ1_DONE: same as port 0, for port 1
- RSP_RDATA  out  16  response data, valid with REQn_DONE
- RSP_ERR  out  1  timeout flag, valid with REQn_DONE
- START_STB  out  1  one-cycle start pulse to the I2C master
- RNW  out  1  to the master; held stable from LAUNCH through RESP
- I2C_ADDR  out  7  to the master; held stable from LAUNCH through RESP
- WR_DATA  out  16  to the master; held stable from LAUNCH through RESP
- I2C_DONE  in  1  completion pulse from the master
- I2C_RD_DATA  in  16  master read data, valid with I2C_DONE
- BUSY  out  1  high in any state except IDLE

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - state=IDLE; all outputs 0; watchdog=0.
  - Round-robin pointer = "last served port 1", so port 0 wins the first tie.
  - Reset mid-transaction aborts silently: no DONE pulse; START_STB is 0 the cycle after.
- All outputs are registered.
- IDLE:
  - If any VALID is high, pick the winner: the single requester, or on a tie the port not last served.
  - Latch the winner's RNW/ADDR/WDATA into RNW/I2C_ADDR/WR_DATA; record the grant; update the pointer; go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - START_STB=1 and the winner's REQn_READY=1.
  - Watchdog cleared; go to WAIT.
  - A VALID seen at edge k therefore produces READY and START_STB in cycle k+1.
- WAIT:
  - I2C_DONE is sampled only here; one in LAUNCH or IDLE is ignored.
  - On I2C_DONE: capture RSP_RDATA = I2C_RD_DATA if RNW=1, else 0; RSP_ERR=0; go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT-1 with no I2C_DONE: RSP_RDATA=0, RSP_ERR=1, go to RESP.
  - If I2C_DONE and the timeout occur in the same cycle, I2C_DONE wins (ERR=0).
- RESP (exactly 1 cycle):
  - Granted REQn_DONE=1; RSP_RDATA and RSP_ERR are valid and then held until the next RESP.
  - Go to IDLE.
  - The next arbitration happens at the IDLE edge, so minimum back-to-back spacing is 4 cycles (IDLE, LAUNCH, WAIT, RESP).
- A requester's VALID change after READY has no effect on the current transaction.
- VALID dropped before READY: the request is not latched if VALID is low at the IDLE sampling edge.
- Only one START_STB per accepted request; never a START_STB outside LAUNCH.
- The watchdog saturates and never wraps: the transition to RESP happens first.

Decomposition:
- Shared package i2c_pkg:
  - FSM state encoding: IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RESP=2'd3.
  - Constants I2C_ADDR_W=7 and I2C_DATA_W=16.
  - Default TIMEOUT.
- One natural sub-module, rr_arb2: 2-input round-robin arbiter with a last-grant pointer. It takes VALID0/VALID1 and an update enable, and returns a grant index.
- The FSM, watchdog and request latches stay in the top module.

Test Plan:
- Single write: REQ0 VALID, ADDR=7'h50, WDATA=16'hA5C3, RNW=0 at edge k → cycle k+1 has START_STB=1, REQ0_READY=1, I2C_ADDR=50h, WR_DATA=A5C3. I2C_DONE 20 cycles later → REQ0_DONE next cycle with RSP_RDATA=0, RSP_ERR=0.
- Single read: REQ1 RNW=1, ADDR=7'h1D; I2C_DONE with I2C_RD_DATA=16'hBEEF → REQ1_DONE=1, RSP_RDATA=BEEF, REQ0_DONE=0.
- Tie fairness: both VALID held continuously → grants alternate 0,1,0,1 over 4 transactions. Exactly 4 START_STB pulses; each port's READY pulses exactly twice.
- Timeout: TIMEOUT=8, no I2C_DONE → DONE with RSP_ERR=1, RSP_RDATA=0, exactly 8 WAIT cycles after LAUNCH. A late I2C_DONE in IDLE is ignored (no extra DONE).
- Collision: I2C_DONE asserted on the final watchdog cycle → RSP_ERR=0 and data captured.
- Reset mid-WAIT: RESET=0 for 1 cycle → BUSY=0, no REQn_DONE, START_STB=0. The next request is accepted normally, with port 0 winning a tie.
